// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer channel selector: FSM state encoding,
// counter width and a saturating increment helper.
package buzzer_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    PLAY     = 2'd0,
    WAIT_LOW = 2'd1,
    GAP      = 2'd2
  } state_t;

  // Counters stick at all-ones instead of wrapping back to zero
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, cleared by the
// synchronous active-low reset.
module sincronizador_2ff
  import buzzer_pkg::*;
(
  input  logic clock_in,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw bit through two flops so the second one is safe to use
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/seletor_buzzer_param.sv
// Glitch-free buzzer source selector. Routes one of NUM_CH square-wave
// sources to the board buzzer; on a channel change it waits for the current
// tone to go low (or times out), forces GAP_CYCLES of silence, then switches.
// Optional build macro: BUZZER_SYNC_EN adds a 2-flop synchroniser per input bit.
module seletor_buzzer_param
  import buzzer_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int SW            = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] buzzer_in,
  input  logic [SW-1:0]     sel_in,
  input  logic              sel_valid,
  output logic              sel_ready,
  input  logic              mute_in,
  output logic              buzzer_placa,
  output logic [SW-1:0]     sel_atual,
  output logic              trocando
);

  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [NUM_CH-1:0] src;

`ifdef BUZZER_SYNC_EN
  for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
    sincronizador_2ff u_sync (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .d_i      (buzzer_in[i]),
      .q_o      (src[i])
    );
  end
`else
  assign src = buzzer_in;
`endif

  state_t         state_q,        state_d;
  logic [SW-1:0]  selAtual_q,     selAtual_d;
  logic [SW-1:0]  pend_q,         pend_d;
  logic [CNT_W-1:0] count_q,      count_d;
  logic           buzzerPlaca_q,  buzzerPlaca_d;

  logic curSrc;
  logic accept;
  logic reqInRange;

  assign curSrc     = src[selAtual_q];
  assign sel_ready  = (state_q == PLAY);
  assign accept     = sel_valid && sel_ready;
  assign reqInRange = (32'(sel_in) < NUM_CH);

  // Next-state logic: play, wait for the old tone to fall, then a silent gap
  always_comb begin
    state_d       = state_q;
    selAtual_d    = selAtual_q;
    pend_d        = pend_q;
    count_d       = count_q;
    buzzerPlaca_d = 1'b0;
    case (state_q)
      PLAY: begin
        buzzerPlaca_d = curSrc & ~mute_in;
        if (accept && reqInRange && (sel_in != selAtual_q)) begin
          pend_d  = sel_in;
          count_d = '0;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        buzzerPlaca_d = curSrc & ~mute_in;
        if (!curSrc || (count_q >= TIMEOUT_LAST)) begin
          count_d = '0;
          state_d = GAP;
        end else begin
          count_d = satInc(count_q);
        end
      end
      GAP: begin
        buzzerPlaca_d = 1'b0;
        if (count_q >= GAP_LAST) begin
          selAtual_d = pend_q;
          count_d    = '0;
          state_d    = PLAY;
        end else begin
          count_d = satInc(count_q);
        end
      end
      default: begin
        state_d = PLAY;
        count_d = '0;
      end
    endcase
  end

  // Register the whole FSM and the buzzer output; reset drops any pending switch
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state_q       <= PLAY;
      selAtual_q    <= '0;
      pend_q        <= '0;
      count_q       <= '0;
      buzzerPlaca_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      selAtual_q    <= selAtual_d;
      pend_q        <= pend_d;
      count_q       <= count_d;
      buzzerPlaca_q <= buzzerPlaca_d;
    end
  end

  assign buzzer_placa = buzzerPlaca_q;
  assign sel_atual    = selAtual_q;
  assign trocando     = (state_q != PLAY);

endmodule

// File: tb/tb_seletor_buzzer_param.sv
// Self-checking bench for seletor_buzzer_param (3 channels, 16-cycle gap,
// 1024-cycle timeout). Works in both builds; LAT tracks BUZZER_SYNC_EN.
module tb_seletor_buzzer_param;

  localparam int NUM_CH  = 3;
  localparam int GAP     = 16;
  localparam int TIMEOUT = 1024;
  localparam int SW      = 2;
`ifdef BUZZER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic              clock_in;
  logic              reset_n;
  logic [NUM_CH-1:0] buzzer_in;
  logic [SW-1:0]     sel_in;
  logic              sel_valid;
  logic              sel_ready;
  logic              mute_in;
  logic              buzzer_placa;
  logic [SW-1:0]     sel_atual;
  logic              trocando;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NUM_CH-1:0] buz;
    logic              mute;
    logic              expOut;
  } vec_t;

  vec_t vecs[8];

  seletor_buzzer_param #(
    .NUM_CH         (NUM_CH),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .buzzer_in    (buzzer_in),
    .sel_in       (sel_in),
    .sel_valid    (sel_valid),
    .sel_ready    (sel_ready),
    .mute_in      (mute_in),
    .buzzer_placa (buzzer_placa),
    .sel_atual    (sel_atual),
    .trocando     (trocando)
  );

  // Free-running 10 ns clock
  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock_in);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_CH-1:0] buz, input logic mute);
    buzzer_in = buz;
    mute_in   = mute;
  endtask

  task automatic request(input logic [SW-1:0] ch);
    sel_in    = ch;
    sel_valid = 1'b1;
    tick(1);
    sel_valid = 1'b0;
  endtask

  // Main directed sequence
  initial begin
    vecs[0] = '{3'b001, 1'b0, 1'b1};
    vecs[1] = '{3'b000, 1'b0, 1'b0};
    vecs[2] = '{3'b001, 1'b1, 1'b0};
    vecs[3] = '{3'b110, 1'b0, 1'b0};
    vecs[4] = '{3'b111, 1'b0, 1'b1};
    vecs[5] = '{3'b110, 1'b1, 1'b0};
    vecs[6] = '{3'b101, 1'b0, 1'b1};
    vecs[7] = '{3'b111, 1'b1, 1'b0};

    reset_n   = 1'b0;
    sel_in    = '0;
    sel_valid = 1'b0;
    applyStimulus(3'b111, 1'b0);
    tick(3);
    checkOutput("reset_out", 16'(buzzer_placa), 16'd0);
    checkOutput("reset_sel", 16'(sel_atual), 16'd0);
    checkOutput("reset_trocando", 16'(trocando), 16'd0);

    reset_n = 1'b1;
    checkOutput("ready_after_release", 16'(sel_ready), 16'd1);
    tick(LAT - 1);
    checkOutput("latency_before", 16'(buzzer_placa), 16'd0);
    tick(1);
    checkOutput("latency_at", 16'(buzzer_placa), 16'd1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].buz, vecs[i].mute);
      tick(LAT);
      checkOutput($sformatf("vec%0d_out", i), 16'(buzzer_placa), 16'(vecs[i].expOut));
    end

    applyStimulus(3'b001, 1'b0);
    tick(LAT);
    mute_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput($sformatf("mute_cycle%0d", i), 16'(buzzer_placa), 16'd0);
      if (i == 4) mute_in = 1'b0;
    end
    tick(1);
    checkOutput("mute_released", 16'(buzzer_placa), 16'd1);

    request(2'd3);
    checkOutput("oob_trocando", 16'(trocando), 16'd0);
    tick(2);
    checkOutput("oob_sel", 16'(sel_atual), 16'd0);
    request(2'd0);
    checkOutput("same_trocando", 16'(trocando), 16'd0);
    checkOutput("same_ready", 16'(sel_ready), 16'd1);

    // Glitch-free switch 0 -> 2 while channel 0 is high
    applyStimulus(3'b101, 1'b0);
    tick(LAT);
    request(2'd2);
    checkOutput("sw_trocando", 16'(trocando), 16'd1);
    checkOutput("sw_ready", 16'(sel_ready), 16'd0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checkOutput($sformatf("sw_hold%0d", i), 16'(buzzer_placa), 16'd1);
    end
    applyStimulus(3'b100, 1'b0);
    tick(LAT - 1);
    checkOutput("sw_before_fall", 16'(buzzer_placa), 16'd1);
    // One cycle of channel 0's own low, then GAP silent cycles
    for (int i = 0; i <= GAP; i++) begin
      if (i == 5) begin
        sel_in    = 2'd1;
        sel_valid = 1'b1;
      end
      if (i == 6) sel_valid = 1'b0;
      tick(1);
      checkOutput($sformatf("gap_out%0d", i), 16'(buzzer_placa), 16'd0);
      checkOutput($sformatf("gap_trocando%0d", i), 16'(trocando), (i < GAP) ? 16'd1 : 16'd0);
    end
    checkOutput("sw_sel_done", 16'(sel_atual), 16'd2);
    tick(1);
    checkOutput("sw_follow_ch2", 16'(buzzer_placa), 16'd1);
    tick(3);
    checkOutput("gap_req_ignored", 16'(trocando), 16'd0);
    checkOutput("gap_req_sel", 16'(sel_atual), 16'd2);

    // Timeout: channel 2 held high, request channel 1
    request(2'd1);
    tick(TIMEOUT);
    checkOutput("to_last_wait", 16'(buzzer_placa), 16'd1);
    tick(1);
    checkOutput("to_gap_entered", 16'(buzzer_placa), 16'd0);
    tick(GAP - 2);
    checkOutput("to_sel_before", 16'(sel_atual), 16'd2);
    checkOutput("to_trocando_before", 16'(trocando), 16'd1);
    tick(1);
    checkOutput("to_sel_after", 16'(sel_atual), 16'd1);
    checkOutput("to_trocando_after", 16'(trocando), 16'd0);

    // Reset in the middle of a GAP abandons the pending channel
    request(2'd2);
    tick(4);
    checkOutput("mid_in_gap", 16'(trocando), 16'd1);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    checkOutput("mid_trocando", 16'(trocando), 16'd0);
    checkOutput("mid_sel", 16'(sel_atual), 16'd0);
    checkOutput("mid_ready", 16'(sel_ready), 16'd1);
    tick(20);
    checkOutput("mid_sel_kept", 16'(sel_atual), 16'd0);
    applyStimulus(3'b001, 1'b0);
    tick(LAT);
    checkOutput("mid_follow_ch0", 16'(buzzer_placa), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seletor_buzzer_param.md
SELETOR_BUZZER_PARAM -- requirements
Module: seletor_buzzer_param

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of buzzer source channels (legal 2..16).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 16, meaning the forced-silence cycles between channel switches (legal 1..65535).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum cycles spent waiting for the current source to go low before a forced switch (legal 1..65535).
REQ-004 The block SHALL use derived constant SW = max(1, clog2(NUM_CH)) as the selection width.
REQ-005 Port clock_in, input, 1 bit: single system clock; all logic SHALL be on its rising edge.
REQ-006 Port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 Port buzzer_in, input, NUM_CH bits: square-wave outputs of the music blocks, bit i = channel i.
REQ-008 Port sel_in, input, SW bits: requested channel.
REQ-009 Port sel_valid, input, 1 bit: sel_in holds a valid request.
REQ-010 Port sel_ready, output, 1 bit: the block accepts a request this cycle.
REQ-011 Port mute_in, input, 1 bit: forces buzzer_placa low while high.
REQ-012 Port buzzer_placa, output, 1 bit: registered buzzer output to the board.
REQ-013 Port sel_atual, output, SW bits: the channel currently routed.
REQ-014 Port trocando, output, 1 bit: high while a switch is in progress (any state other than PLAY).

Function
REQ-015 The FSM SHALL have the states PLAY, WAIT_LOW and GAP.
REQ-016 In PLAY, buzzer_placa SHALL be set each cycle to src[sel_atual] AND NOT mute_in, where src is buzzer_in after the optional synchroniser.
REQ-017 sel_ready SHALL be 1 only in PLAY, and a request is accepted when sel_valid AND sel_ready are both high.
REQ-018 An accepted request with sel_in >= NUM_CH SHALL be discarded with no state change.
REQ-019 An accepted request with sel_in = sel_atual SHALL be consumed with no state change.
REQ-020 On any other accepted request, the block SHALL latch sel_in into pend, clear the timeout counter and enter WAIT_LOW.
REQ-021 In WAIT_LOW, the output SHALL keep following the old channel, so the tone is never truncated mid-high.
REQ-022 The block SHALL leave WAIT_LOW for GAP in the first cycle in which src[sel_atual] = 0 or the counter reaches TIMEOUT_CYCLES-1.
REQ-023 In GAP, buzzer_placa SHALL be 0 for exactly GAP_CYCLES cycles.
REQ-024 On the last GAP cycle, sel_atual SHALL load pend and the FSM SHALL return to PLAY.
REQ-025 sel_valid SHALL be ignored outside PLAY, and no request is queued.
REQ-026 mute_in SHALL act in every state, with a 1-cycle output latency, and SHALL NOT alter FSM progress.
REQ-027 Counters SHALL be 16 bits wide, SHALL saturate and SHALL never wrap.
REQ-028 Input-to-output latency SHALL be 1 cycle without synchroniser and 3 cycles with it.

Reset
REQ-029 While reset_n = 0 at a clock edge, the block SHALL set: state = PLAY, sel_atual = 0, pend = 0, counters = 0, buzzer_placa = 0, synchroniser flops = 0.
REQ-030 A reset asserted mid-switch SHALL abandon the pending request.
REQ-031 sel_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-032 With macro BUZZER_SYNC_EN defined, each buzzer_in bit SHALL pass through a 2-flop synchroniser before use.
REQ-033 Without BUZZER_SYNC_EN, buzzer_in SHALL be used directly, and the port list SHALL be identical in both builds.

Structure
REQ-034 Shared package buzzer_pkg SHALL hold the FSM state typedef (PLAY/WAIT_LOW/GAP) and the 16-bit counter width constant.
REQ-035 The block SHALL use one sub-module, sincronizador_2ff (1-bit, clock_in/reset_n), instantiated NUM_CH times under BUZZER_SYNC_EN.

Verification
REQ-036 Reset check: reset_n low for 3 cycles with buzzer_in = 4'b1111 -> buzzer_placa = 0 and sel_atual = 0; after release, buzzer_placa follows buzzer_in[0] at the specified latency.
REQ-037 Glitch-free switch: channel 0 = 1 kHz square wave, request sel_in = 2 while channel 0 is high -> output stays high until channel 0 falls, then 16 cycles of 0, then follows channel 2; trocando is high for the whole transition.
REQ-038 Timeout: channel 0 held at 1, request sel_in = 1 -> GAP entered after exactly 1024 WAIT_LOW cycles, and sel_atual = 1 after 16 more cycles.
REQ-039 Ignored requests: NUM_CH = 3 with sel_in = 3 -> no change; sel_in = sel_atual -> trocando stays 0; sel_valid pulses during GAP -> ignored.
REQ-040 Mute and mid-switch reset: mute_in pulsed high for 5 cycles in PLAY -> output 0 for 5 cycles; reset_n pulsed low during GAP -> state PLAY, sel_atual = 0.
REQ-041 Build variants: run REQ-036 to REQ-040 both with and without BUZZER_SYNC_EN -> latency difference of exactly 2 cycles.
